// File: rtl/logic_shift_pipe.sv
// Two-stage logic/compare/shift unit: S1 captures the op, S2 holds the computed result.
// Valid/ready on both sides; flush squashes everything in flight.
module logic_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_operand_1,
  input  logic [WIDTH-1:0] in_operand_2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_NOR  = 4'd3,
    OP_SLT  = 4'd4,
    OP_SLTU = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_LUI  = 4'd9
  } op_e;

  logic             s1_valid_reg;
  logic [3:0]       s1_op_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] s2_result_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  logic             s2_illegal_reg;

  logic             s2_free;
  logic             s1_advance;
  logic             accept;

  assign s2_free    = !s2_valid_reg || out_ready;
  // Flush voids both handshakes, so nothing moves in that cycle.
  assign s1_advance = s1_valid_reg && s2_free && !flush;
  assign in_ready   = !flush && (!s1_valid_reg || s2_free);
  assign accept     = in_valid && in_ready;

  // Shifter: one right-shifting barrel; left shifts reverse the bits on the way in and out.
  logic [SHW-1:0]   shamt;
  logic             shift_left;
  logic             shift_fill;
  logic [WIDTH-1:0] b_rev;
  logic [WIDTH-1:0] left_result;
  logic [WIDTH-1:0] shift_stage [SHW+1];

  assign shamt      = s1_a_reg[SHW-1:0];
  assign shift_left = (s1_op_reg == OP_SLL);
  assign shift_fill = (s1_op_reg == OP_SRA) && s1_b_reg[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign b_rev[gi]       = s1_b_reg[WIDTH-1-gi];
      assign left_result[gi] = shift_stage[SHW][WIDTH-1-gi];
    end
  endgenerate

  assign shift_stage[0] = shift_left ? b_rev : s1_b_reg;

  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_shift
      localparam int STEP = 1 << gi;
      assign shift_stage[gi+1] = shamt[gi]
        ? {{STEP{shift_fill}}, shift_stage[gi][WIDTH-1:STEP]}
        : shift_stage[gi];
    end
  endgenerate

  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] result_next;
  logic             illegal_next;

  assign lt_signed   = $signed(s1_a_reg) < $signed(s1_b_reg);
  assign lt_unsigned = s1_a_reg < s1_b_reg;

  always_comb begin
    result_next  = '0;
    illegal_next = 1'b0;
    case (s1_op_reg)
      OP_AND:  result_next = s1_a_reg & s1_b_reg;
      OP_OR:   result_next = s1_a_reg | s1_b_reg;
      OP_XOR:  result_next = s1_a_reg ^ s1_b_reg;
      OP_NOR:  result_next = ~(s1_a_reg | s1_b_reg);
      OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: result_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SLL:  result_next = left_result;
      OP_SRL:  result_next = shift_stage[SHW];
      OP_SRA:  result_next = shift_stage[SHW];
      OP_LUI:  result_next = {s1_b_reg[HALF-1:0], {HALF{1'b0}}};
      default: illegal_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_op_reg      <= '0;
      s1_a_reg       <= '0;
      s1_b_reg       <= '0;
      s1_tag_reg     <= '0;
      s2_valid_reg   <= 1'b0;
      s2_result_reg  <= '0;
      s2_tag_reg     <= '0;
      s2_illegal_reg <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_reg <= 1'b0;
        s2_valid_reg <= 1'b0;
      end else begin
        if (accept)          s1_valid_reg <= 1'b1;
        else if (s1_advance) s1_valid_reg <= 1'b0;
        if (s1_advance)      s2_valid_reg <= 1'b1;
        else if (out_ready)  s2_valid_reg <= 1'b0;
      end
      if (accept) begin
        s1_op_reg  <= in_op;
        s1_a_reg   <= in_operand_1;
        s1_b_reg   <= in_operand_2;
        s1_tag_reg <= in_tag;
      end
      if (s1_advance) begin
        s2_result_reg  <= result_next;
        s2_tag_reg     <= s1_tag_reg;
        s2_illegal_reg <= illegal_next;
      end
    end
  end

  assign out_valid   = s2_valid_reg;
  assign out_result  = s2_result_reg;
  assign out_tag     = s2_tag_reg;
  assign out_illegal = s2_illegal_reg;

endmodule

// File: tb/tb_logic_shift_pipe.sv
// Scoreboard bench for logic_shift_pipe: stimulus queues expected results, monitors pop and compare.
// A second instance at WIDTH=16 covers the narrow-width shift and illegal cases.
module tb_logic_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_operand_1;
  logic [31:0] in_operand_2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_illegal;

  logic        n_flush;
  logic        n_in_valid;
  logic        n_in_ready;
  logic [3:0]  n_in_op;
  logic [15:0] n_operand_1;
  logic [15:0] n_operand_2;
  logic [4:0]  n_in_tag;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [15:0] n_out_result;
  logic [4:0]  n_out_tag;
  logic        n_out_illegal;

  always #5 clk = ~clk;

  logic_shift_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_operand_1(in_operand_1), .in_operand_2(in_operand_2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  logic_shift_pipe #(.WIDTH(16), .TAG_W(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_op(n_in_op),
    .in_operand_1(n_operand_1), .in_operand_2(n_operand_2), .in_tag(n_in_tag),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_result(n_out_result),
    .out_tag(n_out_tag), .out_illegal(n_out_illegal)
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  tag;
    logic        illegal;
    int          exp_cyc;
  } exp_t;

  exp_t q[$];
  exp_t q16[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit instance: ordering, latency, and stall stability.
  bit          stall_seen = 0;
  logic [31:0] held_result;
  logic [4:0]  held_tag;
  logic        held_illegal;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_seen = 0;
    end else if (flush) begin
      q.delete();
      stall_seen = 0;
    end else begin
      if (stall_seen && out_valid) begin
        checks++;
        if (out_result !== held_result || out_tag !== held_tag || out_illegal !== held_illegal) begin
          errors++;
          $display("FAIL stall_hold got %h/%0d/%b expected %h/%0d/%b",
                   out_result, out_tag, out_illegal, held_result, held_tag, held_illegal);
        end
      end
      if (out_valid && out_ready) begin
        exp_t e;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got %h tag %0d expected no output", out_result, out_tag);
        end else begin
          e = q.pop_front();
          if (out_result !== e.result || out_tag !== e.tag || out_illegal !== e.illegal) begin
            errors++;
            $display("FAIL result got %h tag %0d ill %b expected %h tag %0d ill %b",
                     out_result, out_tag, out_illegal, e.result, e.tag, e.illegal);
          end else begin
            $display("out  tag %0d result %h illegal %b", out_tag, out_result, out_illegal);
          end
          if (e.exp_cyc >= 0) begin
            checks++;
            if (cyc != e.exp_cyc) begin
              errors++;
              $display("FAIL latency tag %0d got cycle %0d expected %0d", e.tag, cyc, e.exp_cyc);
            end
          end
        end
      end
      stall_seen   = out_valid && !out_ready;
      held_result  = out_result;
      held_tag     = out_tag;
      held_illegal = out_illegal;
    end
  end

  always @(negedge clk) begin
    if (rst_n && n_out_valid && n_out_ready) begin
      exp_t e;
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL w16_unexpected got %h expected no output", n_out_result);
      end else begin
        e = q16.pop_front();
        if (n_out_result !== e.result[15:0] || n_out_tag !== e.tag || n_out_illegal !== e.illegal) begin
          errors++;
          $display("FAIL w16_result got %h tag %0d ill %b expected %h tag %0d ill %b",
                   n_out_result, n_out_tag, n_out_illegal, e.result[15:0], e.tag, e.illegal);
        end else begin
          $display("w16 out tag %0d result %h illegal %b", n_out_tag, n_out_result, n_out_illegal);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] res, input logic ill,
                      input bit chk_lat);
    bit done = 0;
    int waited = 0;
    in_valid = 1'b1; in_op = op; in_operand_1 = a; in_operand_2 = b; in_tag = tag;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{res, tag, ill, chk_lat ? cyc + 2 : -1});
        $display("in   tag %0d op %0d a %h b %h", tag, op, a, b);
        done = 1;
      end else if (++waited > 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout tag %0d got in_ready 0 expected 1", tag);
        done = 1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] tag, input logic [15:0] res, input logic ill);
    n_in_valid = 1'b1; n_in_op = op; n_operand_1 = a; n_operand_2 = b; n_in_tag = tag;
    @(negedge clk);
    chk("w16_in_ready", {31'd0, n_in_ready}, 32'd1);
    if (n_in_ready) q16.push_back('{{16'd0, res}, tag, ill, -1});
    @(posedge clk); #1;
    n_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int waited;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'd1; in_operand_1 = 32'hFFFF_FFFF; in_operand_2 = 32'h1; in_tag = 5'd7;
    n_flush = 1'b0; n_in_valid = 1'b0; n_in_op = 4'd0; n_operand_1 = '0; n_operand_2 = '0;
    n_in_tag = '0; n_out_ready = 1'b1;

    // Reset holds everything quiet even with an op offered.
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back compares with latency checking.
    send(4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 5'd1, 32'd1, 1'b0, 1);
    send(4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 5'd2, 32'd0, 1'b0, 1);
    send(4'd4, 32'h7FFF_FFFF, 32'h8000_0000, 5'd3, 32'd0, 1'b0, 1);
    send(4'd5, 32'h7FFF_FFFF, 32'h8000_0000, 5'd4, 32'd1, 1'b0, 1);
    // Logic ops.
    send(4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5, 32'h00F0_00F0, 1'b0, 1);
    send(4'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 32'hFFF0_FFF0, 1'b0, 1);
    send(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd7, 32'hFF00_FF00, 1'b0, 1);
    send(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd8, 32'h000F_000F, 1'b0, 1);
    // Shifts, LUI, illegal.
    send(4'd8, 32'd4,  32'h8000_0000, 5'd9,  32'hF800_0000, 1'b0, 1);
    send(4'd8, 32'd0,  32'h8000_0000, 5'd10, 32'h8000_0000, 1'b0, 1);
    send(4'd7, 32'd31, 32'h8000_0000, 5'd11, 32'h0000_0001, 1'b0, 1);
    send(4'd6, 32'd31, 32'h0000_0001, 5'd12, 32'h8000_0000, 1'b0, 1);
    send(4'd7, 32'h24, 32'h8000_0000, 5'd13, 32'h0800_0000, 1'b0, 1);
    send(4'd9, 32'd0,  32'h0000_1234, 5'd14, 32'h1234_0000, 1'b0, 1);
    send(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'd0, 1'b1, 1);
    idle(4);

    // Backpressure: two accepted, third waits until the first drain cycle.
    out_ready = 1'b0;
    send(4'd2, 32'h1111_1111, 32'h2222_2222, 5'd16, 32'h3333_3333, 1'b0, 0);
    send(4'd0, 32'hFFFF_0000, 32'h1234_5678, 5'd17, 32'h1234_0000, 1'b0, 0);
    in_valid = 1'b1; in_op = 4'd1; in_operand_1 = 32'hA000_0000; in_operand_2 = 32'h0000_000B; in_tag = 5'd18;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_drain", {31'd0, in_ready}, 32'd1);
    if (in_ready) q.push_back('{32'hA000_000B, 5'd18, 1'b0, -1});
    @(posedge clk); #1;
    idle(5);

    // Flush with two ops in flight; neither may appear.
    out_ready = 1'b0;
    send(4'd1, 32'h0000_00F0, 32'h0000_000F, 5'd19, 32'h0000_00FF, 1'b0, 0);
    send(4'd2, 32'h0000_00F0, 32'h0000_000F, 5'd20, 32'h0000_00FF, 1'b0, 0);
    flush = 1'b1; out_ready = 1'b1;
    in_op = 4'd0; in_tag = 5'd21;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    idle(4);
    send(4'd9, 32'd0, 32'h0000_ABCD, 5'd22, 32'hABCD_0000, 1'b0, 1);
    idle(4);

    // Reset mid-operation drops the in-flight op.
    out_ready = 1'b0;
    send(4'd1, 32'h5, 32'h6, 5'd23, 32'h7, 1'b0, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    idle(5);

    // Narrow instance.
    send16(4'd8, 16'd15, 16'h8000, 5'd24, 16'hFFFF, 1'b0);
    send16(4'd15, 16'hFFFF, 16'hFFFF, 5'd25, 16'h0000, 1'b1);
    send16(4'd6, 16'd4, 16'h0123, 5'd26, 16'h1230, 1'b0);

    waited = 0;
    while ((q.size() != 0 || q16.size() != 0) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (q.size() != 0 || q16.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d/%0d pending expected 0/0", q.size(), q16.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
